// File: rtl/alu_writeback.sv
// Purpose : buffers ALU results with their flags in an in-order FIFO; tracks PSR, sticky overflow and dropped illegal ops.
// Latency : one cycle; a result accepted on edge k is visible at the head in the cycle after edge k.
// Backpr. : in_ready drops when DEPTH entries are stored; a same-cycle pop does not reopen it.
//
// Ports:
//   clk, rst                        clock, async active-high reset
//   in_valid/in_ready               upstream result handshake
//   in_sel, in_y                    opcode and 32-bit result
//   in_cout/in_neg/in_zero/in_ovf   ALU flags
//   out_valid/out_ready             downstream handshake
//   out_y, out_flags                head entry result and {N,Z,C,V}; zero when empty
//   psr                             flags of the last committed result
//   sticky_ovf, sticky_clr          sticky overflow flag and its clear
//   illegal_cnt                     saturating count of dropped illegal-opcode results
//   occupancy                       entries currently stored
module alu_writeback #(
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [3:0]                 in_sel,
   input  logic [31:0]                in_y,
   input  logic                       in_cout,
   input  logic                       in_neg,
   input  logic                       in_zero,
   input  logic                       in_ovf,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [31:0]                out_y,
   output logic [3:0]                 out_flags,
   output logic [3:0]                 psr,
   output logic                       sticky_ovf,
   input  logic                       sticky_clr,
   output logic [7:0]                 illegal_cnt,
   output logic [$clog2(DEPTH):0]     occupancy
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL = DEPTH[AW:0];

   // Entry layout: {Y[31:0], N, Z, C, V}
   logic [35:0]   r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_occ;
   logic [3:0]    r_psr;
   logic          r_sticky;
   logic [7:0]    r_ill_cnt;

   logic          w_illegal;
   logic          w_accept;
   logic          w_push;
   logic          w_pop;
   logic [35:0]   w_head;
   logic [3:0]    w_in_flags;

   assign w_illegal  = (in_sel == 4'b1001) || (in_sel == 4'b1110) || (in_sel == 4'b1111);
   assign w_in_flags = {in_neg, in_zero, in_cout, in_ovf};

   // Handshakes come from registered occupancy only; rst gates in_ready so
   // nothing is accepted while reset is held.
   assign in_ready  = !rst && (r_occ < FULL);
   assign out_valid = (r_occ != '0);

   assign w_accept = in_valid && in_ready;
   assign w_push   = w_accept && !w_illegal;
   assign w_pop    = out_valid && out_ready;

   assign w_head    = r_mem[r_rd_ptr];
   assign out_y     = out_valid ? w_head[35:4] : 32'h0;
   assign out_flags = out_valid ? w_head[3:0]  : 4'h0;

   assign psr         = r_psr;
   assign sticky_ovf  = r_sticky;
   assign illegal_cnt = r_ill_cnt;
   assign occupancy   = r_occ;

   // Storage is not reset: outputs are masked by out_valid, and occupancy
   // decides which slots are meaningful.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= {in_y, w_in_flags};
      end
   end

   // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_occ    <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_occ <= r_occ + 1'b1;
            2'b01:   r_occ <= r_occ - 1'b1;
            default: r_occ <= r_occ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_psr     <= '0;
         r_sticky  <= 1'b0;
         r_ill_cnt <= '0;
      end else begin
         if (w_push) r_psr <= w_in_flags;
         // A new overflow beats a clear arriving on the same edge.
         if (w_push && in_ovf)  r_sticky <= 1'b1;
         else if (sticky_clr)   r_sticky <= 1'b0;
         if (w_accept && w_illegal && (r_ill_cnt != 8'hFF)) begin
            r_ill_cnt <= r_ill_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_alu_writeback.sv
// Purpose : directed self-checking bench for alu_writeback (DEPTH=4).
// Latency : inputs change 2 time units after each rising edge; outputs are checked there too.
// Backpr. : out_ready is driven explicitly by each scenario.
module tb_alu_writeback;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  in_sel;
   logic [31:0] in_y;
   logic        in_cout, in_neg, in_zero, in_ovf;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_y;
   logic [3:0]  out_flags;
   logic [3:0]  psr;
   logic        sticky_ovf;
   logic        sticky_clr;
   logic [7:0]  illegal_cnt;
   logic [2:0]  occupancy;

   int n_checks = 0;
   int n_errors = 0;

   alu_writeback #(.DEPTH(4)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel), .in_y(in_y),
      .in_cout(in_cout), .in_neg(in_neg), .in_zero(in_zero), .in_ovf(in_ovf),
      .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y), .out_flags(out_flags),
      .psr(psr), .sticky_ovf(sticky_ovf), .sticky_clr(sticky_clr),
      .illegal_cnt(illegal_cnt), .occupancy(occupancy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic set_in(input logic v, input logic [3:0] sel, input logic [31:0] y,
                         input logic n, input logic z, input logic c, input logic o);
      in_valid = v; in_sel = sel; in_y = y;
      in_neg = n; in_zero = z; in_cout = c; in_ovf = o;
   endtask

   task automatic test_reset();
      #1;
      n_checks++; if (occupancy !== 3'd0) begin n_errors++; $display("FAIL rst_occ: got %0d want 0", occupancy); end
      n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
      n_checks++; if (in_ready !== 1'b0) begin n_errors++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
      n_checks++; if (out_y !== 32'h0 || out_flags !== 4'h0) begin n_errors++; $display("FAIL rst_out_data: got %h/%b want 0/0", out_y, out_flags); end
      n_checks++; if (psr !== 4'h0 || sticky_ovf !== 1'b0 || illegal_cnt !== 8'd0) begin n_errors++; $display("FAIL rst_status: got psr=%b sticky=%b ill=%0d want 0/0/0", psr, sticky_ovf, illegal_cnt); end
      tick();
      rst = 1'b0;
      #1;
      n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL rst_release_ready: got %b want 1", in_ready); end
   endtask

   task automatic test_basic();
      set_in(1'b1, 4'b0110, 32'h5, 1'b0, 1'b0, 1'b0, 1'b0);
      out_ready = 1'b1;
      tick();
      set_in(1'b0, 4'b0000, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      n_checks++; if (out_valid !== 1'b1 || out_y !== 32'h5) begin n_errors++; $display("FAIL basic_head: got v=%b y=%h want 1/5", out_valid, out_y); end
      n_checks++; if (out_flags !== 4'b0000 || psr !== 4'b0000 || occupancy !== 3'd1) begin n_errors++; $display("FAIL basic_flags: got f=%b psr=%b occ=%0d want 0000/0000/1", out_flags, psr, occupancy); end
      tick();
      n_checks++; if (out_valid !== 1'b0 || out_y !== 32'h0) begin n_errors++; $display("FAIL basic_empty: got v=%b y=%h want 0/0", out_valid, out_y); end
   endtask

   task automatic test_full();
      logic [3:0] exp_f;
      out_ready = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         set_in(1'b1, 4'b0000, 32'(i), (i == 1), (i == 4), (i == 4), 1'b0);
         tick();
      end
      set_in(1'b1, 4'b0001, 32'h5, 1'b1, 1'b0, 1'b0, 1'b0);
      #1;
      n_checks++; if (in_ready !== 1'b0 || occupancy !== 3'd4) begin n_errors++; $display("FAIL full_state: got rdy=%b occ=%0d want 0/4", in_ready, occupancy); end
      tick();
      n_checks++; if (occupancy !== 3'd4 || psr !== 4'b0110) begin n_errors++; $display("FAIL full_reject: got occ=%0d psr=%b want 4/0110", occupancy, psr); end
      out_ready = 1'b1;
      #1;
      n_checks++; if (in_ready !== 1'b0) begin n_errors++; $display("FAIL full_pop_ready: got %b want 0", in_ready); end
      set_in(1'b0, 4'b0000, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 1; i <= 4; i++) begin
         exp_f = (i == 1) ? 4'b1000 : ((i == 4) ? 4'b0110 : 4'b0000);
         n_checks++; if (out_valid !== 1'b1 || out_y !== 32'(i) || out_flags !== exp_f) begin n_errors++; $display("FAIL full_drain%0d: got v=%b y=%h f=%b want 1/%h/%b", i, out_valid, out_y, out_flags, i, exp_f); end
         tick();
      end
      n_checks++; if (out_valid !== 1'b0 || occupancy !== 3'd0) begin n_errors++; $display("FAIL full_drained: got v=%b occ=%0d want 0/0", out_valid, occupancy); end
   endtask

   task automatic test_illegal();
      logic [3:0] sels [3];
      sels[0] = 4'b1001; sels[1] = 4'b1110; sels[2] = 4'b1111;
      out_ready = 1'b0;
      set_in(1'b1, 4'b1001, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b1);
      tick();
      n_checks++; if (illegal_cnt !== 8'd1) begin n_errors++; $display("FAIL ill_cnt1: got %0d want 1", illegal_cnt); end
      n_checks++; if (occupancy !== 3'd0 || out_valid !== 1'b0) begin n_errors++; $display("FAIL ill_occ: got occ=%0d v=%b want 0/0", occupancy, out_valid); end
      n_checks++; if (psr !== 4'b0110 || sticky_ovf !== 1'b0) begin n_errors++; $display("FAIL ill_psr: got psr=%b sticky=%b want 0110/0", psr, sticky_ovf); end
      for (int i = 0; i < 254; i++) begin
         in_sel = sels[i % 3];
         tick();
      end
      n_checks++; if (illegal_cnt !== 8'd255) begin n_errors++; $display("FAIL ill_cnt255: got %0d want 255", illegal_cnt); end
      tick();
      n_checks++; if (illegal_cnt !== 8'd255) begin n_errors++; $display("FAIL ill_saturate: got %0d want 255", illegal_cnt); end
      set_in(1'b0, 4'b0000, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_sticky();
      out_ready = 1'b0;
      sticky_clr = 1'b1;
      set_in(1'b1, 4'b0110, 32'h8000_0000, 1'b1, 1'b0, 1'b0, 1'b1);
      tick();
      set_in(1'b0, 4'b0000, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      n_checks++; if (sticky_ovf !== 1'b1 || psr !== 4'b1001) begin n_errors++; $display("FAIL sticky_set_wins: got sticky=%b psr=%b want 1/1001", sticky_ovf, psr); end
      n_checks++; if (out_y !== 32'h8000_0000 || out_flags !== 4'b1001) begin n_errors++; $display("FAIL sticky_head: got y=%h f=%b want 80000000/1001", out_y, out_flags); end
      out_ready = 1'b1;
      tick();
      sticky_clr = 1'b0;
      n_checks++; if (sticky_ovf !== 1'b0 || psr !== 4'b1001 || occupancy !== 3'd0) begin n_errors++; $display("FAIL sticky_clear: got sticky=%b psr=%b occ=%0d want 0/1001/0", sticky_ovf, psr, occupancy); end
   endtask

   task automatic test_occ1();
      out_ready = 1'b0;
      set_in(1'b1, 4'b0000, 32'h0000_0AAA, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      set_in(1'b1, 4'b1101, 32'h0000_0BBB, 1'b0, 1'b1, 1'b0, 1'b0);
      out_ready = 1'b1;
      n_checks++; if (out_y !== 32'h0000_0AAA) begin n_errors++; $display("FAIL occ1_first: got %h want aaa", out_y); end
      tick();
      set_in(1'b0, 4'b0000, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      n_checks++; if (occupancy !== 3'd1 || out_y !== 32'h0000_0BBB || out_flags !== 4'b0100) begin n_errors++; $display("FAIL occ1_new: got occ=%0d y=%h f=%b want 1/bbb/0100", occupancy, out_y, out_flags); end
      tick();
      n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL occ1_empty: got %b want 0", out_valid); end
   endtask

   task automatic test_back_to_back();
      out_ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         set_in(1'b1, 4'b0010, 32'(100 + i), 1'b0, 1'b0, 1'b0, 1'b0);
         tick();
      end
      out_ready = 1'b1;
      for (int i = 0; i < 12; i++) begin
         set_in(1'b1, 4'b0010, 32'(102 + i), 1'b0, 1'b0, 1'b0, 1'b0);
         n_checks++; if (out_y !== 32'(100 + i)) begin n_errors++; $display("FAIL b2b_order%0d: got %0d want %0d", i, out_y, 100 + i); end
         tick();
         n_checks++; if (occupancy !== 3'd2) begin n_errors++; $display("FAIL b2b_occ%0d: got %0d want 2", i, occupancy); end
      end
      set_in(1'b0, 4'b0000, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      n_checks++; if (out_y !== 32'd112) begin n_errors++; $display("FAIL b2b_tail0: got %0d want 112", out_y); end
      tick();
      n_checks++; if (out_y !== 32'd113) begin n_errors++; $display("FAIL b2b_tail1: got %0d want 113", out_y); end
      tick();
      n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL b2b_empty: got %b want 0", out_valid); end
   endtask

   task automatic test_reset_mid();
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         set_in(1'b1, 4'b0011, 32'h00C0_0000 + 32'(i), 1'b0, 1'b0, 1'b1, 1'b1);
         tick();
      end
      set_in(1'b0, 4'b0000, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      n_checks++; if (occupancy !== 3'd3 || sticky_ovf !== 1'b1) begin n_errors++; $display("FAIL mid_pre: got occ=%0d sticky=%b want 3/1", occupancy, sticky_ovf); end
      #3;
      rst = 1'b1;
      #1;
      n_checks++; if (out_valid !== 1'b0 || occupancy !== 3'd0 || in_ready !== 1'b0) begin n_errors++; $display("FAIL mid_async: got v=%b occ=%0d rdy=%b want 0/0/0", out_valid, occupancy, in_ready); end
      n_checks++; if (out_y !== 32'h0 || psr !== 4'h0 || sticky_ovf !== 1'b0) begin n_errors++; $display("FAIL mid_clear: got y=%h psr=%b sticky=%b want 0/0/0", out_y, psr, sticky_ovf); end
      #10;
      rst = 1'b0;
      #1;
      n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL mid_release_ready: got %b want 1", in_ready); end
      out_ready = 1'b1;
      tick();
      tick();
      n_checks++; if (out_valid !== 1'b0 || occupancy !== 3'd0 || out_y !== 32'h0) begin n_errors++; $display("FAIL mid_no_stale: got v=%b occ=%0d y=%h want 0/0/0", out_valid, occupancy, out_y); end
   endtask

   initial begin
      rst = 1'b1;
      out_ready = 1'b0;
      sticky_clr = 1'b0;
      set_in(1'b0, 4'b0000, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      test_reset();
      test_basic();
      test_full();
      test_illegal();
      test_sticky();
      test_occ1();
      test_back_to_back();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
